// File: rtl/if_inst_queue.sv
// rtl/if_inst_queue.sv - instruction fetch queue between PC generator/ROM and decode
// Optional feature macro: IFQ_OVERFLOW_EN adds a sticky overflow_o flag.
module if_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              flush_i,
  output logic              full_o,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
`ifdef IFQ_OVERFLOW_EN
  ,
  output logic              overflow_o
`endif
);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Status comes from the registered count only, so a full queue rejects a
  // push even when decode pops in the same cycle.
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_valid = (r_count != '0);

  // Handshake qualification; flush overrides both directions.
  always_comb begin
    w_push = ce_i & ~w_full & ~flush_i;
    w_pop  = w_valid & id_ready_i & ~flush_i;
  end

  // Storage is never cleared; outputs are masked by count instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= pc_i;
      r_inst_mem[r_wr_ptr] <= inst_i;
    end
  end

  // Pointer and occupancy bookkeeping: reset, then flush, then push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full_o     = w_full;
  assign id_valid_o = w_valid;
  // Empty queue presents a zero pc and a nop instruction to decode.
  assign id_pc_o    = w_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign id_inst_o  = w_valid ? r_inst_mem[r_rd_ptr] : '0;

`ifdef IFQ_OVERFLOW_EN
  logic r_overflow;

  // Sticky record of any fetch attempted against a full queue; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (ce_i & w_full & ~flush_i) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
`endif

endmodule

// File: tb/tb_if_inst_queue.sv
// tb/tb_if_inst_queue.sv - directed self-checking bench for if_inst_queue
module tb_if_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        full_o;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
`ifdef IFQ_OVERFLOW_EN
  logic        overflow_o;
`endif

  int checks = 0;
  int errors = 0;

  if_inst_queue #(.DEPTH(4), .AW(2), .ADDR_W(32), .INST_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .pc_i       (pc_i),
    .inst_i     (inst_i),
    .flush_i    (flush_i),
    .full_o     (full_o),
    .id_ready_i (id_ready_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
`ifdef IFQ_OVERFLOW_EN
    ,
    .overflow_o (overflow_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    ce_i = 1'b0; id_ready_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_i = 1'b1; pc_i = 32'h55; inst_i = 32'h66; id_ready_i = 1'b0; flush_i = 1'b0;
    repeat (3) tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_valid_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", id_pc_o); end
    checks++; if (id_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", id_inst_o); end
`ifdef IFQ_OVERFLOW_EN
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_o); end
`endif
    rst = 1'b0; ce_i = 1'b0;
  endtask

  task automatic test_fill_drain();
    clear_q();
    id_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ce_i = 1'b1; pc_i = 32'(i * 4); inst_i = 32'hA0 + 32'(i);
      tick();
      checks++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'hA0) begin
        errors++; $display("FAIL fill_head[%0d] got %h/%h exp 0/a0", i, id_pc_o, id_inst_o);
      end
      checks++; if (full_o !== (i == 3)) begin
        errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full_o, (i == 3));
      end
    end
    pc_i = 32'h10; inst_i = 32'hA4;
    tick();
    checks++; if (full_o !== 1'b1 || id_pc_o !== 32'h0) begin
      errors++; $display("FAIL drop_push got full=%b pc=%h exp full=1 pc=0", full_o, id_pc_o);
    end
    ce_i = 1'b0; id_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(i * 4) || id_inst_o !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL drain[%0d] got v=%b %h/%h exp v=1 %h/%h", i, id_valid_o, id_pc_o, id_inst_o, i * 4, 32'hA0 + 32'(i));
      end
      tick();
    end
    checks++; if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin
      errors++; $display("FAIL drain_empty got v=%b %h/%h exp v=0 0/0", id_valid_o, id_pc_o, id_inst_o);
    end
    id_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_q();
    id_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ce_i = 1'b1; pc_i = 32'h100 + 32'(i * 4); inst_i = 32'hC0 + 32'(i);
      tick();
      checks++; if (id_valid_o !== 1'b1 || full_o !== 1'b0 || id_pc_o !== 32'h100 + 32'(i * 4) || id_inst_o !== 32'hC0 + 32'(i)) begin
        errors++; $display("FAIL b2b[%0d] got v=%b f=%b %h/%h exp v=1 f=0 %h/%h", i, id_valid_o, full_o, id_pc_o, id_inst_o, 32'h100 + 32'(i * 4), 32'hC0 + 32'(i));
      end
    end
    ce_i = 1'b0;
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%b exp 0", id_valid_o); end
    id_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    clear_q();
    for (int i = 0; i < 3; i++) begin
      ce_i = 1'b1; pc_i = 32'h300 + 32'(i * 4); inst_i = 32'hD0 + 32'(i);
      tick();
    end
    flush_i = 1'b1; ce_i = 1'b1; pc_i = 32'h20; inst_i = 32'hEE; id_ready_i = 1'b1;
    tick();
    checks++; if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0) begin
      errors++; $display("FAIL flush got v=%b pc=%h exp v=0 pc=0", id_valid_o, id_pc_o);
    end
    flush_i = 1'b0; ce_i = 1'b0;
    tick();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_nopush got v=%b exp 0", id_valid_o); end
    id_ready_i = 1'b0;
  endtask

  task automatic test_full_pop_push();
    clear_q();
    for (int i = 0; i < 4; i++) begin
      ce_i = 1'b1; pc_i = 32'h30 + 32'(i * 4); inst_i = 32'hF0 + 32'(i);
      tick();
    end
    id_ready_i = 1'b1; ce_i = 1'b1; pc_i = 32'h40; inst_i = 32'hFF;
    tick();
    checks++; if (full_o !== 1'b0 || id_pc_o !== 32'h34) begin
      errors++; $display("FAIL fullpp got f=%b pc=%h exp f=0 pc=34", full_o, id_pc_o);
    end
`ifdef IFQ_OVERFLOW_EN
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_o); end
`endif
    ce_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h30 + 32'(i * 4)) begin
        errors++; $display("FAIL fullpp_drain[%0d] got v=%b pc=%h exp v=1 pc=%h", i, id_valid_o, id_pc_o, 32'h30 + 32'(i * 4));
      end
      tick();
    end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL fullpp_absent got v=%b pc=%h exp v=0", id_valid_o, id_pc_o); end
    id_ready_i = 1'b0;
`ifdef IFQ_OVERFLOW_EN
    clear_q();
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_o); end
`endif
  endtask

  task automatic test_random_stream();
    logic [63:0] q[$];
    logic        do_push;
    logic        do_pop;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    clear_q();
    while (got < 10 && cyc < 200) begin
      id_ready_i = 1'($urandom_range(0, 1));
      ce_i   = (sent < 10);
      pc_i   = 32'h200 + 32'(sent * 4);
      inst_i = 32'hB0 + 32'(sent);
      checks++; if (id_valid_o !== (q.size() != 0) || full_o !== (q.size() == 4)) begin
        errors++; $display("FAIL rnd_status cyc %0d got v=%b f=%b exp v=%b f=%b", cyc, id_valid_o, full_o, (q.size() != 0), (q.size() == 4));
      end
      if (q.size() != 0) begin
        checks++; if ({id_pc_o, id_inst_o} !== q[0]) begin
          errors++; $display("FAIL rnd_head cyc %0d got %h/%h exp %h", cyc, id_pc_o, id_inst_o, q[0]);
        end
      end
      do_push = ce_i && (q.size() < 4);
      do_pop  = (q.size() != 0) && id_ready_i;
      tick();
      if (do_pop) begin
        void'(q.pop_front());
        got++;
      end
      if (do_push) begin
        q.push_back({pc_i, inst_i});
        sent++;
      end
      cyc++;
    end
    checks++; if (got != 10) begin errors++; $display("FAIL rnd_count got %0d exp 10", got); end
    ce_i = 1'b0; id_ready_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    clear_q();
    for (int i = 0; i < 2; i++) begin
      ce_i = 1'b1; pc_i = 32'h400 + 32'(i * 4); inst_i = 32'h1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; ce_i = 1'b0;
    checks++; if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0) begin
      errors++; $display("FAIL mid_reset got v=%b pc=%h exp v=0 pc=0", id_valid_o, id_pc_o);
    end
`ifdef IFQ_OVERFLOW_EN
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow_o); end
`endif
  endtask

  initial begin
    rst = 1'b1; ce_i = 1'b0; pc_i = '0; inst_i = '0; flush_i = 1'b0; id_ready_i = 1'b0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_full_pop_push();
    test_random_stream();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
